// File: rtl/tl_pkg.sv
// Shared encodings for the intersection phase sequencer: phase codes,
// operator mode codes, lamp patterns and the lamp decode helpers.
package tl_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        AR_AB    = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        AR_BA    = 3'd5,
        FLASH    = 3'd6
    } phase_e;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FLASH  = 2'b01;
    localparam logic [1:0] MODE_HOLD_A = 2'b10;
    localparam logic [1:0] MODE_HOLD_B = 2'b11;

    // Lamp bits are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic logic [2:0] lamp_a(input phase_e st, input logic flash_on);
        case (st)
            A_GREEN:  return LAMP_GRN;
            A_YELLOW: return LAMP_YEL;
            FLASH:    return flash_on ? LAMP_YEL : LAMP_OFF;
            default:  return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input phase_e st, input logic flash_on);
        case (st)
            B_GREEN:  return LAMP_GRN;
            B_YELLOW: return LAMP_YEL;
            FLASH:    return flash_on ? LAMP_YEL : LAMP_OFF;
            default:  return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Operator/pedestrian inputs and lamp/display outputs of the phase sequencer.
interface traffic_phase_sequencer_if;
    logic       tick;
    logic [1:0] mode;
    logic       ped_a;
    logic       ped_b;
    logic [2:0] A_lights;
    logic [2:0] B_lights;
    logic       walk_a;
    logic       walk_b;
    logic [3:0] num_out;
    logic [2:0] phase;

    modport master (
        output tick, mode, ped_a, ped_b,
        input  A_lights, B_lights, walk_a, walk_b, num_out, phase
    );

    modport slave (
        input  tick, mode, ped_a, ped_b,
        output A_lights, B_lights, walk_a, walk_b, num_out, phase
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_a,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/traffic_phase_sequencer.sv
// Tick-driven green/yellow/all-red scheduler for roads A and B with
// pedestrian gap-out, hold and flash modes; all outputs are registered.
module traffic_phase_sequencer
    import tl_pkg::*;
#(
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_GAP    = 2
) (
    input logic clk,
    input logic rst_a,
    traffic_phase_sequencer_if.slave bus
);
    localparam logic [3:0] G_LOAD   = 4'(T_GREEN - 1);
    localparam logic [3:0] Y_LOAD   = 4'(T_YELLOW - 1);
    localparam logic [3:0] AR_LOAD  = 4'(T_ALLRED - 1);
    localparam logic [3:0] GAP_LOAD = 4'(T_GAP - 1);
    localparam logic [3:0] GAP_VAL  = 4'(T_GAP);

    // Bits 1:0 mode, bit 2 ped_a, bit 3 ped_b
    logic [3:0] sync_in;
    logic [3:0] sync_out;
    assign sync_in = {bus.ped_b, bus.ped_a, bus.mode};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            sync2 u_sync (
                .clk   (clk),
                .rst_a (rst_a),
                .d     (sync_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    logic [1:0] mode_s;
    logic       ped_a_s;
    logic       ped_b_s;
    assign mode_s  = sync_out[1:0];
    assign ped_a_s = sync_out[2];
    assign ped_b_s = sync_out[3];

    phase_e     state_reg, state_next;
    logic [3:0] remain_reg, remain_next;
    logic       flash_reg, flash_next;
    logic       pend_a_reg, pend_a_next;
    logic       pend_b_reg, pend_b_next;
    logic       serve_a_reg, serve_a_next;
    logic       serve_b_reg, serve_b_next;
    logic       run_reg;
    logic [2:0] a_lights_reg, b_lights_reg;
    logic       walk_a_reg, walk_b_reg;
    logic [3:0] num_out_reg;

    // A tick on the first edge after reset release is swallowed by run_reg
    logic tick_en;
    assign tick_en = bus.tick & run_reg;

    always_comb begin
        state_next   = state_reg;
        remain_next  = remain_reg;
        flash_next   = flash_reg;
        pend_a_next  = pend_a_reg | ped_a_s;
        pend_b_next  = pend_b_reg | ped_b_s;
        serve_a_next = serve_a_reg;
        serve_b_next = serve_b_reg;
        if (tick_en) begin
            case (state_reg)
                A_GREEN: begin
                    if (mode_s == MODE_FLASH || mode_s == MODE_HOLD_B) begin
                        state_next  = A_YELLOW;
                        remain_next = Y_LOAD;
                    end else if (remain_reg == 4'd0) begin
                        if (mode_s != MODE_HOLD_A) begin
                            state_next  = A_YELLOW;
                            remain_next = Y_LOAD;
                        end
                    end else if (mode_s == MODE_NORMAL && pend_a_reg && remain_reg > GAP_VAL) begin
                        remain_next = GAP_LOAD;
                    end else begin
                        remain_next = remain_reg - 4'd1;
                    end
                end
                A_YELLOW: begin
                    if (remain_reg == 4'd0) begin
                        state_next  = AR_AB;
                        remain_next = AR_LOAD;
                    end else begin
                        remain_next = remain_reg - 4'd1;
                    end
                end
                AR_AB: begin
                    if (remain_reg != 4'd0) begin
                        remain_next = remain_reg - 4'd1;
                    end else if (mode_s == MODE_FLASH) begin
                        state_next  = FLASH;
                        remain_next = 4'd0;
                        flash_next  = 1'b0;
                    end else begin
                        state_next   = B_GREEN;
                        remain_next  = G_LOAD;
                        serve_a_next = pend_a_reg;
                        pend_a_next  = ped_a_s;
                    end
                end
                B_GREEN: begin
                    if (mode_s == MODE_FLASH || mode_s == MODE_HOLD_A) begin
                        state_next  = B_YELLOW;
                        remain_next = Y_LOAD;
                    end else if (remain_reg == 4'd0) begin
                        if (mode_s != MODE_HOLD_B) begin
                            state_next  = B_YELLOW;
                            remain_next = Y_LOAD;
                        end
                    end else if (mode_s == MODE_NORMAL && pend_b_reg && remain_reg > GAP_VAL) begin
                        remain_next = GAP_LOAD;
                    end else begin
                        remain_next = remain_reg - 4'd1;
                    end
                end
                B_YELLOW: begin
                    if (remain_reg == 4'd0) begin
                        state_next  = AR_BA;
                        remain_next = AR_LOAD;
                    end else begin
                        remain_next = remain_reg - 4'd1;
                    end
                end
                AR_BA: begin
                    if (remain_reg != 4'd0) begin
                        remain_next = remain_reg - 4'd1;
                    end else if (mode_s == MODE_FLASH) begin
                        state_next  = FLASH;
                        remain_next = 4'd0;
                        flash_next  = 1'b0;
                    end else begin
                        state_next   = A_GREEN;
                        remain_next  = G_LOAD;
                        serve_b_next = pend_b_reg;
                        pend_b_next  = ped_b_s;
                    end
                end
                FLASH: begin
                    if (mode_s != MODE_FLASH) begin
                        state_next  = AR_BA;
                        remain_next = AR_LOAD;
                    end else begin
                        flash_next = ~flash_reg;
                    end
                end
                default: begin
                    state_next  = AR_BA;
                    remain_next = AR_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_reg    <= AR_BA;
            remain_reg   <= AR_LOAD;
            flash_reg    <= 1'b0;
            pend_a_reg   <= 1'b0;
            pend_b_reg   <= 1'b0;
            serve_a_reg  <= 1'b0;
            serve_b_reg  <= 1'b0;
            run_reg      <= 1'b0;
            a_lights_reg <= LAMP_RED;
            b_lights_reg <= LAMP_RED;
            walk_a_reg   <= 1'b0;
            walk_b_reg   <= 1'b0;
            num_out_reg  <= AR_LOAD;
        end else begin
            state_reg    <= state_next;
            remain_reg   <= remain_next;
            flash_reg    <= flash_next;
            pend_a_reg   <= pend_a_next;
            pend_b_reg   <= pend_b_next;
            serve_a_reg  <= serve_a_next;
            serve_b_reg  <= serve_b_next;
            run_reg      <= 1'b1;
            a_lights_reg <= lamp_a(state_next, flash_next);
            b_lights_reg <= lamp_b(state_next, flash_next);
            walk_a_reg   <= (state_next == B_GREEN) && serve_a_next;
            walk_b_reg   <= (state_next == A_GREEN) && serve_b_next;
            num_out_reg  <= (state_next == FLASH) ? 4'd0 : remain_next;
        end
    end

    assign bus.A_lights = a_lights_reg;
    assign bus.B_lights = b_lights_reg;
    assign bus.walk_a   = walk_a_reg;
    assign bus.walk_b   = walk_b_reg;
    assign bus.num_out  = num_out_reg;
    assign bus.phase    = state_reg;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: table-driven phase model checked every
// cycle, directed scenario steps with literal expectations, then random traffic.
module tb_traffic_phase_sequencer;
    localparam int T_GREEN  = 8;
    localparam int T_YELLOW = 3;
    localparam int T_ALLRED = 1;
    localparam int T_GAP    = 2;

    logic       clk   = 1'b0;
    logic       rst_a = 1'b1;
    logic       tick  = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic       ped_a = 1'b0;
    logic       ped_b = 1'b0;
    bit         tick_rand = 1'b0;
    bit         cmp_on = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         tcnt = 0;

    traffic_phase_sequencer_if bus ();
    assign bus.tick  = tick;
    assign bus.mode  = mode;
    assign bus.ped_a = ped_a;
    assign bus.ped_b = ped_b;

    traffic_phase_sequencer #(
        .T_GREEN (T_GREEN),
        .T_YELLOW(T_YELLOW),
        .T_ALLRED(T_ALLRED),
        .T_GAP   (T_GAP)
    ) dut (
        .clk  (clk),
        .rst_a(rst_a),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Phase cycle 0..5 with durations and lamps; 6 is the flash phase
    int dur_tab [6] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};
    int lamp_a_tab [6] = '{1, 2, 4, 4, 4, 4};
    int lamp_b_tab [6] = '{4, 4, 4, 1, 2, 4};

    int   m_phase = 5;
    int   m_rem   = T_ALLRED - 1;
    bit   m_fl    = 1'b0;
    bit   m_run   = 1'b0;
    bit   m_pend  [2] = '{1'b0, 1'b0};
    bit   m_serve [2] = '{1'b0, 1'b0};
    bit   m_ps1   [2] = '{1'b0, 1'b0};
    bit   m_ps2   [2] = '{1'b0, 1'b0};
    int   m_ms1   = 0;
    int   m_ms2   = 0;
    int   m_ticks = 0;

    always @(posedge clk or posedge rst_a) begin : model
        int  p, r, ms, nx, road, c;
        bit  fl, green, own_hold, yield_now;
        bit  pend [2];
        bit  sv [2];
        if (rst_a) begin
            m_phase <= 5; m_rem <= T_ALLRED - 1; m_fl <= 1'b0; m_run <= 1'b0;
            m_pend  <= '{1'b0, 1'b0}; m_serve <= '{1'b0, 1'b0};
            m_ps1   <= '{1'b0, 1'b0}; m_ps2   <= '{1'b0, 1'b0};
            m_ms1   <= 0; m_ms2 <= 0;
        end else begin
            p = m_phase; r = m_rem; fl = m_fl; ms = m_ms2;
            sv = m_serve;
            pend[0] = m_pend[0] | m_ps2[0];
            pend[1] = m_pend[1] | m_ps2[1];
            if (tick && m_run) begin
                if (p == 6) begin
                    if (ms != 1) begin p = 5; r = T_ALLRED - 1; end
                    else fl = !fl;
                end else begin
                    green     = (p % 3 == 0);
                    road      = p / 3;
                    own_hold  = (ms == 2 && road == 0) || (ms == 3 && road == 1);
                    yield_now = green && (ms == 1 || (ms >= 2 && !own_hold));
                    if (yield_now) begin
                        p = p + 1; r = T_YELLOW - 1;
                    end else if (r == 0) begin
                        if (!(green && own_hold)) begin
                            nx = (p + 1) % 6;
                            if (nx % 3 == 0 && ms == 1) begin
                                p = 6; r = 0; fl = 1'b0;
                            end else begin
                                p = nx; r = dur_tab[nx] - 1;
                                if (nx % 3 == 0) begin
                                    c = 1 - nx / 3;
                                    sv[c]   = m_pend[c];
                                    pend[c] = m_ps2[c];
                                end
                            end
                        end
                    end else if (green && ms == 0 && m_pend[road] && r > T_GAP) begin
                        r = T_GAP - 1;
                    end else begin
                        r = r - 1;
                    end
                end
                m_ticks <= m_ticks + 1;
            end
            m_phase <= p; m_rem <= r; m_fl <= fl; m_run <= 1'b1;
            m_pend  <= pend; m_serve <= sv;
            m_ps1   <= '{ped_a, ped_b}; m_ps2 <= m_ps1;
            m_ms1   <= int'(mode); m_ms2 <= m_ms1;
        end
    end

    function automatic int exp_lamp(input bit road_b);
        if (m_phase == 6) return m_fl ? 2 : 0;
        return road_b ? lamp_b_tab[m_phase] : lamp_a_tab[m_phase];
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_phase",  int'(bus.phase),    m_phase);
            check("cyc_num",    int'(bus.num_out),  m_rem);
            check("cyc_A",      int'(bus.A_lights), exp_lamp(1'b0));
            check("cyc_B",      int'(bus.B_lights), exp_lamp(1'b1));
            check("cyc_walk_a", int'(bus.walk_a),   int'(m_serve[0] && m_phase == 3));
            check("cyc_walk_b", int'(bus.walk_b),   int'(m_serve[1] && m_phase == 0));
        end
    end

    initial begin : tick_gen
        forever begin
            @(negedge clk);
            if (tick_rand) begin
                tick = ($urandom_range(0, 2) == 0);
            end else begin
                tcnt = (tcnt + 1) % 4;
                tick = (tcnt == 0);
            end
        end
    end

    task automatic wait_ticks(input int n);
        int t0;
        int budget;
        t0 = m_ticks;
        budget = 40 * n;
        while (m_ticks < t0 + n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("wait_ticks", m_ticks - t0, n);
        $display("tick %0d: phase=%0d num=%0d A=%b B=%b walk=%b%b", m_ticks,
                 bus.phase, bus.num_out, bus.A_lights, bus.B_lights, bus.walk_a, bus.walk_b);
    endtask

    task automatic expect_pn(input string nm, input int ph, input int nv);
        check({nm, "_phase"}, int'(bus.phase), ph);
        check({nm, "_num"},   int'(bus.num_out), nv);
    endtask

    initial begin : main
        int budget;
        repeat (3) @(negedge clk);
        expect_pn("reset", 5, 0);
        check("reset_A", int'(bus.A_lights), 4);
        check("reset_B", int'(bus.B_lights), 4);
        check("reset_walk", int'({bus.walk_a, bus.walk_b}), 0);
        rst_a = 1'b0;
        cmp_on = 1'b1;

        // Normal cycle
        wait_ticks(1);  expect_pn("first_agreen", 0, 7);
        wait_ticks(8);  expect_pn("a_yellow", 1, 2);
        wait_ticks(3);  expect_pn("ar_ab", 2, 0);
        wait_ticks(1);  expect_pn("b_green", 3, 7);
        wait_ticks(12); expect_pn("period24", 0, 7);

        // Pedestrian A gap-out
        wait_ticks(1);  expect_pn("ped_pre", 0, 6);
        ped_a = 1'b1;
        @(negedge clk);
        ped_a = 1'b0;
        wait_ticks(1);  expect_pn("gapout", 0, 1);
        wait_ticks(1);  expect_pn("gapout_end", 0, 0);
        wait_ticks(1);  expect_pn("gap_yellow", 1, 2);
        wait_ticks(4);  expect_pn("walk_green", 3, 7);
        check("walk_a_on", int'(bus.walk_a), 1);

        // HOLD_A from B_GREEN
        wait_ticks(2);  expect_pn("holdA_pre", 3, 5);
        mode = 2'b10;
        wait_ticks(1);  expect_pn("holdA_yield", 4, 2);
        wait_ticks(3);  expect_pn("holdA_arba", 5, 0);
        wait_ticks(1);  expect_pn("holdA_agreen", 0, 7);
        wait_ticks(12); expect_pn("holdA_frozen", 0, 0);
        check("holdA_lamp", int'(bus.A_lights), 1);
        mode = 2'b00;
        wait_ticks(1);  expect_pn("holdA_release", 1, 2);

        // FLASH from A_GREEN
        wait_ticks(16); expect_pn("flash_pre", 0, 7);
        mode = 2'b01;
        wait_ticks(1);  expect_pn("flash_yield", 1, 2);
        wait_ticks(3);  expect_pn("flash_arab", 2, 0);
        wait_ticks(1);  expect_pn("flash_in", 6, 0);
        check("flash_off0", int'({bus.A_lights, bus.B_lights}), 0);
        wait_ticks(1);  check("flash_on1", int'({bus.A_lights, bus.B_lights}), 6'o22);
        wait_ticks(1);  check("flash_off2", int'({bus.A_lights, bus.B_lights}), 0);
        mode = 2'b00;
        wait_ticks(1);  expect_pn("flash_exit", 5, 0);
        wait_ticks(1);  expect_pn("flash_agreen", 0, 7);

        // Async reset mid A_YELLOW; tick on the release edge must be ignored
        wait_ticks(8);  expect_pn("rst_pre", 1, 2);
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        expect_pn("rst_async", 5, 0);
        check("rst_async_A", int'(bus.A_lights), 4);
        check("rst_async_B", int'(bus.B_lights), 4);
        repeat (3) @(negedge clk);
        budget = 20;
        do begin
            @(negedge clk);
            #1;
            budget--;
        end while (!tick && budget > 0);
        check("rst_tick_found", int'(tick), 1);
        rst_a = 1'b0;
        @(negedge clk);
        expect_pn("rst_release", 5, 0);
        wait_ticks(1);  expect_pn("rst_restart", 0, 7);

        // ped_b held high: every B_GREEN gapped out, every A_GREEN walks
        ped_b = 1'b1;
        wait_ticks(12); expect_pn("pedb_bgreen", 3, 7);
        wait_ticks(1);  expect_pn("pedb_gap", 3, 1);
        wait_ticks(2);  expect_pn("pedb_yellow", 4, 2);
        wait_ticks(4);  expect_pn("pedb_agreen", 0, 7);
        check("walk_b_on", int'(bus.walk_b), 1);
        ped_b = 1'b0;

        // Random traffic against the model
        tick_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: mode = 2'b00;
                    4:          mode = 2'b01;
                    5:          mode = 2'b10;
                    6:          mode = 2'b11;
                    default:    mode = 2'b00;
                endcase
            end
            ped_a = ($urandom_range(0, 40) == 0) ? ~ped_a : ped_a;
            ped_b = ($urandom_range(0, 40) == 0) ? ~ped_b : ped_b;
        end
        tick_rand = 1'b0;
        @(negedge clk);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
